// File: rtl/regfile_bypass.sv
// Multi-ported register file with a hardwired-zero register 0 and a write counter.
// Optional same-cycle write-to-read forwarding. Reads are combinational.
module regfile_bypass #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic [15:0]      wr_count
);

  // Mux slots cover the whole address space; slots at or above DEPTH stay zero.
  localparam int NSLOT = 1 << AW;

  logic [DEPTH-1:1][WIDTH-1:0] mem_q, mem_d;
  logic [15:0]                 wr_count_q, wr_count_d;
  logic                        wr_ok;
  logic [WIDTH-1:0][NSLOT-1:0] bits_t;
  logic [WIDTH-1:0]            stored0, stored1;
  logic                        hit0, hit1;

  always_comb begin
    wr_ok = we && (waddr != '0) && (int'(waddr) < DEPTH);
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 1; i < DEPTH; i++) begin
      if (wr_ok && (waddr == AW'(i))) begin
        mem_d[i] = wdata;
      end
    end
    wr_count_d = wr_count_q + (wr_ok ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q      <= '0;
      wr_count_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Bit-transposed view: bits_t[b] holds bit b of every register, slot 0 is register 0.
  always_comb begin
    bits_t = '0;
    for (int b = 0; b < WIDTH; b++) begin
      for (int r = 1; r < DEPTH; r++) begin
        bits_t[b][r] = mem_q[r][b];
      end
    end
  end

  always_comb begin
    stored0 = '0;
    stored1 = '0;
    for (int b = 0; b < WIDTH; b++) begin
      stored0[b] = bits_t[b][raddr0];
      stored1[b] = bits_t[b][raddr1];
    end
  end

  always_comb begin
    hit0 = (BYPASS != 0) && wr_ok && (waddr == raddr0);
    hit1 = (BYPASS != 0) && wr_ok && (waddr == raddr1);
  end

  // Reset forces the read ports to zero, including any forwarded data.
  always_comb begin
    rdata0 = '0;
    rdata1 = '0;
    if (!reset) begin
      rdata0 = hit0 ? wdata : stored0;
      rdata1 = hit1 ? wdata : stored1;
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: default build, a no-forwarding build and a
// DEPTH=16 build all see the same stimulus and are checked against hand values.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr0 = '0;
  logic [4:0]  raddr1 = '0;

  logic [31:0] rd0_a, rd1_a, rd0_n, rd1_n, rd0_s, rd1_s;
  logic [15:0] cnt_a, cnt_n, cnt_s;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  regfile_bypass #(.WIDTH(32), .DEPTH(32), .AW(5), .BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_a), .rdata1(rd1_a), .wr_count(cnt_a)
  );

  regfile_bypass #(.WIDTH(32), .DEPTH(32), .AW(5), .BYPASS(0)) u_n (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_n), .rdata1(rd1_n), .wr_count(cnt_n)
  );

  regfile_bypass #(.WIDTH(32), .DEPTH(16), .AW(5), .BYPASS(1)) u_s (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_s), .rdata1(rd1_s), .wr_count(cnt_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    we    = en;
    waddr = a;
    wdata = d;
  endtask

  initial begin
    // Reset, then every index on both ports reads zero
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr0 = 5'(i);
      raddr1 = 5'(31 - i);
      #1;
      check("rst_rd0_a", rd0_a, 0);
      check("rst_rd1_a", rd1_a, 0);
      check("rst_rd0_s", rd0_s, 0);
      check("rst_rd1_s", rd1_s, 0);
    end
    check("rst_cnt_a", cnt_a, 0);
    check("rst_cnt_n", cnt_n, 0);
    check("rst_cnt_s", cnt_s, 0);
    step();

    // Write 5, read on both ports next cycle
    drive_wr(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    raddr0 = 5'd5;
    raddr1 = 5'd5;
    #1;
    check("w5_rd0_a", rd0_a, 32'hDEADBEEF);
    check("w5_rd1_a", rd1_a, 32'hDEADBEEF);
    check("w5_rd0_n", rd0_n, 32'hDEADBEEF);
    check("w5_rd0_s", rd0_s, 32'hDEADBEEF);
    check("w5_cnt_a", cnt_a, 1);
    check("w5_cnt_s", cnt_s, 1);

    // Same-cycle forwarding vs. none
    raddr0 = 5'd7;
    raddr1 = 5'd5;
    drive_wr(1'b1, 5'd7, 32'h1234);
    #1;
    check("byp_rd0_a", rd0_a, 32'h1234);
    check("byp_rd0_n_old", rd0_n, 32'h0);
    check("byp_rd0_s", rd0_s, 32'h1234);
    check("byp_rd1_a", rd1_a, 32'hDEADBEEF);
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    #1;
    check("byp_rd0_n_new", rd0_n, 32'h1234);
    check("byp_rd0_a_new", rd0_a, 32'h1234);
    check("byp_cnt_n", cnt_n, 2);

    // Register 0 is never written or forwarded
    raddr0 = 5'd0;
    drive_wr(1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    check("r0_byp_a", rd0_a, 0);
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    #1;
    check("r0_rd0_a", rd0_a, 0);
    check("r0_cnt_a", cnt_a, 2);
    check("r0_cnt_s", cnt_s, 2);

    // Index 20 is out of range only for the DEPTH=16 build
    raddr0 = 5'd20;
    raddr1 = 5'd20;
    drive_wr(1'b1, 5'd20, 32'h5);
    #1;
    check("oor_byp_a", rd0_a, 32'h5);
    check("oor_byp_s", rd0_s, 32'h0);
    check("oor_byp_n", rd0_n, 32'h0);
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    #1;
    check("oor_rd0_a", rd0_a, 32'h5);
    check("oor_rd1_a", rd1_a, 32'h5);
    check("oor_rd0_s", rd0_s, 32'h0);
    check("oor_rd1_s", rd1_s, 32'h0);
    check("oor_rd0_n", rd0_n, 32'h5);
    check("oor_cnt_a", cnt_a, 3);
    check("oor_cnt_s", cnt_s, 2);
    check("oor_cnt_n", cnt_n, 3);

    // Rewriting an unchanged value still counts
    drive_wr(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    #1;
    check("same_cnt_a", cnt_a, 4);
    check("same_cnt_s", cnt_s, 3);
    check("same_cnt_n", cnt_n, 4);

    // Fill 1..31 with their own index
    for (int i = 1; i < 32; i++) begin
      drive_wr(1'b1, 5'(i), 32'(i));
      exp_q.push_back(32'(i));
      step();
    end
    drive_wr(1'b0, 5'd0, 32'h0);
    #1;
    check("fill_cnt_a", cnt_a, 35);
    check("fill_cnt_n", cnt_n, 35);
    check("fill_cnt_s", cnt_s, 18);
    for (int i = 1; i < 32; i++) begin
      raddr0 = 5'(i);
      raddr1 = 5'(i);
      #1;
      e = exp_q.pop_front();
      check("fill_rd0_a", rd0_a, e);
      check("fill_rd1_a", rd1_a, e);
      check("fill_rd0_n", rd0_n, e);
      check("fill_rd0_s", rd0_s, (i < 16) ? 32'(i) : 32'h0);
    end

    // Asynchronous reset between edges clears everything at once
    step();
    #3;
    raddr0 = 5'd31;
    raddr1 = 5'd9;
    reset = 1'b1;
    #1;
    check("arst_rd0_a", rd0_a, 0);
    check("arst_rd1_a", rd1_a, 0);
    check("arst_cnt_a", cnt_a, 0);
    check("arst_cnt_n", cnt_n, 0);
    check("arst_cnt_s", cnt_s, 0);

    // Write held across an edge while reset is high is dropped; no forwarding either
    raddr0 = 5'd3;
    drive_wr(1'b1, 5'd3, 32'h33);
    #1;
    check("rst_byp_a", rd0_a, 0);
    step();
    check("rst_wr_cnt_a", cnt_a, 0);
    check("rst_wr_rd0_a", rd0_a, 0);

    // First edge after release commits normally
    reset = 1'b0;
    #1;
    check("rel_byp_a", rd0_a, 32'h33);
    check("rel_old_n", rd0_n, 32'h0);
    step();
    drive_wr(1'b0, 5'd0, 32'h0);
    #1;
    check("rel_cnt_a", cnt_a, 1);
    check("rel_cnt_n", cnt_n, 1);
    check("rel_cnt_s", cnt_s, 1);
    check("rel_rd0_n", rd0_n, 32'h33);

    // Nothing from before the reset survives
    for (int i = 1; i < 32; i++) begin
      raddr0 = 5'(i);
      raddr1 = 5'(i);
      #1;
      check("post_rd0_a", rd0_a, (i == 3) ? 32'h33 : 32'h0);
      check("post_rd1_s", rd1_s, (i == 3) ? 32'h33 : 32'h0);
    end

    // Counter wrap after 65536 committed writes
    step();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("wrap_start_a", cnt_a, 0);
    drive_wr(1'b1, 5'd1, 32'hABC);
    repeat (65535) @(posedge clk);
    #1;
    check("wrap_ffff_a", cnt_a, 16'hFFFF);
    @(posedge clk);
    #1;
    check("wrap_zero_a", cnt_a, 0);
    check("wrap_zero_s", cnt_s, 0);
    check("wrap_zero_n", cnt_n, 0);
    @(posedge clk);
    #1;
    drive_wr(1'b0, 5'd0, 32'h0);
    check("wrap_one_a", cnt_a, 1);
    check("wrap_one_s", cnt_s, 1);
    check("wrap_one_n", cnt_n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (2..32).
REQ-003 SHALL have parameter AW, default 5, address width; DEPTH <= 2**AW.
REQ-004 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port we, input, 1, write enable.
REQ-008 SHALL have port waddr, input, AW, write register index.
REQ-009 SHALL have port wdata, input, WIDTH, write data.
REQ-010 SHALL have port raddr0, input, AW, read port 0 index.
REQ-011 SHALL have port raddr1, input, AW, read port 1 index.
REQ-012 SHALL have port rdata0, output, WIDTH, read port 0 data (combinational).
REQ-013 SHALL have port rdata1, output, WIDTH, read port 1 data (combinational).
REQ-014 SHALL have port wr_count, output, 16, count of committed writes.

Function
REQ-015 Storage SHALL be DEPTH registers of WIDTH bits, written only on a rising clk edge with we=1 and reset=0.
REQ-016 Register 0 SHALL read as 0 at all times; writes to index 0 SHALL be discarded and not counted.
REQ-017 Writes with waddr >= DEPTH SHALL be discarded and not counted; reads with raddr >= DEPTH SHALL return 0.
REQ-018 rdataN SHALL equal the stored contents of raddrN with zero-cycle latency (combinational on raddrN and storage).
REQ-019 With BYPASS=1, when we=1, waddr=raddrN, waddr!=0 and waddr<DEPTH, rdataN SHALL equal wdata in the same cycle.
REQ-020 With BYPASS=0, rdataN SHALL show the old value during the write cycle and the new value from the following cycle.
REQ-021 Both read ports SHALL be independent; equal raddr0 and raddr1 SHALL return identical data.
REQ-022 wr_count SHALL increment by 1 on each committed write (REQ-015..017) and wrap from 16'hFFFF to 0.
REQ-023 Writing the same value already stored SHALL still count as a committed write.
REQ-024 The read-select path SHALL be built as a per-bit DEPTH-to-1 mux over a bit-transposed storage vector, sized by the parameters, with no hard-coded 32.

Reset
REQ-025 Asserting reset SHALL immediately, without waiting for clk, clear all storage and wr_count to 0; rdata0/rdata1 SHALL read 0 while reset is high (bypass suppressed).
REQ-026 A write coinciding with a clk edge while reset is high SHALL be discarded.
REQ-027 Deassertion of reset SHALL take effect so that the first clk edge with reset=0 and we=1 commits normally.
REQ-028 Reset asserted mid-sequence SHALL leave no partial state; all registers read 0 afterwards.

Verification
REQ-029 Reset then read all indices on both ports -> every rdata = 0, wr_count = 0.
REQ-030 Write 5 <- 32'hDEADBEEF, next cycle raddr0=5, raddr1=5 -> both rdata = 32'hDEADBEEF, wr_count = 1.
REQ-031 we=1, waddr=7, wdata=32'h1234, raddr0=7 in the same cycle -> rdata0 = 32'h1234 before the edge (BYPASS=1); old value 0 before the edge (BYPASS=0), 32'h1234 after.
REQ-032 Write 0 <- 32'hFFFFFFFF; DEPTH=16 build, write 20 <- 32'h5 -> rdata for index 0 and 20 = 0, wr_count unchanged.
REQ-033 Fill registers 1..31 with their index, then assert reset asynchronously between edges -> all rdata = 0 immediately, wr_count = 0.
REQ-034 Issue 65536 committed writes from reset -> wr_count = 0; one more -> wr_count = 1.
